// File: rtl/if_resp_join_q_pkg.sv
package if_resp_join_q_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_INST_W = 32;
  localparam int unsigned FETCH_EXCP_W = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] vaddr;
    logic [FETCH_INST_W-1:0] inst;
    logic                    excp;
    logic [FETCH_EXCP_W-1:0] excp_num;
  } fetch_pair_t;

endpackage

// File: rtl/if_resp_join_q_fetch_sync_fifo.sv
module fetch_sync_fifo
  import if_resp_join_q_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_resp_join_q.sv
module if_resp_join_q
  import if_resp_join_q_pkg::*;
#(
  parameter int unsigned ADDR_W     = FETCH_ADDR_W,
  parameter int unsigned INST_W     = FETCH_INST_W,
  parameter int unsigned EXCP_W     = FETCH_EXCP_W,
  parameter int unsigned PEND_DEPTH = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              excp_flush,
  input  logic              ertn_flush,
  input  logic [ADDR_W-1:0] vaddr,
  input  logic              vaddr_valid,
  output logic              vaddr_ready,
  input  logic [INST_W-1:0] inst_i,
  input  logic              excp_i,
  input  logic [EXCP_W-1:0] excp_num_i,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] vaddr_o,
  output logic              excp,
  output logic [EXCP_W-1:0] excp_num,
  output logic              ib_valid,
  input  logic              ib_ready,
  output logic              is_fire
);

  localparam int unsigned PC_W = $clog2(PEND_DEPTH + 1);
  localparam int unsigned OC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] vaddr;
    logic [INST_W-1:0] inst;
    logic              excp;
    logic [EXCP_W-1:0] excp_num;
  } pair_t;

  logic              kill;
  logic              req_fire;
  logic              resp_fire;
  logic              keep;
  logic              out_pop;
  logic [PC_W-1:0]   pend_cnt;
  logic [PC_W-1:0]   disc_cnt_q, disc_cnt_d;
  logic [OC_W-1:0]   out_cnt;
  logic [ADDR_W-1:0] pend_head;
  pair_t             push_pair;
  pair_t             head_pair;

  always_comb begin
    kill        = flush || excp_flush || ertn_flush;
    vaddr_ready = !kill
                  && ((32'(pend_cnt) + 32'(disc_cnt_q)) < PEND_DEPTH)
                  && ((32'(pend_cnt) + 32'(out_cnt)) < DEPTH);
    inst_ready  = (pend_cnt != '0) || (disc_cnt_q != '0);
    req_fire    = vaddr_valid && vaddr_ready;
    resp_fire   = inst_valid && inst_ready;
    keep        = resp_fire && !kill && (disc_cnt_q == '0);
    is_fire     = keep;
    ib_valid    = (out_cnt != '0);
    out_pop     = ib_valid && ib_ready;

    push_pair.vaddr    = pend_head;
    push_pair.inst     = inst_i;
    push_pair.excp     = excp_i;
    push_pair.excp_num = excp_num_i;

    // Outstanding requests turn into discards on kill; a response landing
    // in the same cycle consumes one of them immediately.
    disc_cnt_d = disc_cnt_q;
    if (kill) begin
      disc_cnt_d = PC_W'(32'(disc_cnt_q) + 32'(pend_cnt) - 32'(resp_fire));
    end else if (resp_fire && (disc_cnt_q != '0)) begin
      disc_cnt_d = disc_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disc_cnt_q <= '0;
    end else begin
      disc_cnt_q <= disc_cnt_d;
    end
  end

  fetch_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (PEND_DEPTH)
  ) u_pend_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (kill),
    .push      (req_fire),
    .push_data (vaddr),
    .pop       (keep),
    .count     (pend_cnt),
    .head      (pend_head)
  );

  fetch_sync_fifo #(
    .WIDTH ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_out_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (kill),
    .push      (keep),
    .push_data (push_pair),
    .pop       (out_pop),
    .count     (out_cnt),
    .head      (head_pair)
  );

  assign inst_o   = head_pair.inst;
  assign vaddr_o  = head_pair.vaddr;
  assign excp     = head_pair.excp;
  assign excp_num = head_pair.excp_num;

endmodule

// File: tb/tb_if_resp_join_q.sv
module tb_if_resp_join_q;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] vaddr;
  logic        vaddr_valid;
  logic        vaddr_ready;
  logic [31:0] inst_i;
  logic        excp_i;
  logic [3:0]  excp_num_i;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] vaddr_o;
  logic        excp;
  logic [3:0]  excp_num;
  logic        ib_valid;
  logic        ib_ready;
  logic        is_fire;

  int passed;
  int total;
  int proto_err;

  if_resp_join_q #(
    .ADDR_W     (32),
    .INST_W     (32),
    .EXCP_W     (4),
    .PEND_DEPTH (2),
    .DEPTH      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .excp_flush  (excp_flush),
    .ertn_flush  (ertn_flush),
    .vaddr       (vaddr),
    .vaddr_valid (vaddr_valid),
    .vaddr_ready (vaddr_ready),
    .inst_i      (inst_i),
    .excp_i      (excp_i),
    .excp_num_i  (excp_num_i),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_o      (inst_o),
    .vaddr_o     (vaddr_o),
    .excp        (excp),
    .excp_num    (excp_num),
    .ib_valid    (ib_valid),
    .ib_ready    (ib_ready),
    .is_fire     (is_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && inst_valid && !inst_ready) proto_err++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    excp_flush  = 1'b0;
    ertn_flush  = 1'b0;
    vaddr_valid = 1'b0;
    inst_valid  = 1'b0;
    excp_i      = 1'b0;
    excp_num_i  = 4'h0;
  endtask

  task automatic test_reset();
    idle();
    vaddr    = 32'h0;
    inst_i   = 32'h0;
    ib_ready = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({ib_valid, inst_ready, is_fire, excp, excp_num} !== 8'h00)
      $display("FAIL reset_flags: got %h required 00", {ib_valid, inst_ready, is_fire, excp, excp_num});
    else passed++;
    total++;
    if ({vaddr_o, inst_o} !== 64'h0)
      $display("FAIL reset_head: got %h required 0", {vaddr_o, inst_o});
    else passed++;
    total++;
    if (vaddr_ready !== 1'b1) $display("FAIL reset_vaddr_ready: got %b required 1", vaddr_ready);
    else passed++;
  endtask

  task automatic test_single();
    idle();
    ib_ready    = 1'b1;
    vaddr       = 32'h1c000000;
    vaddr_valid = 1'b1;
    #1;
    total++;
    if (vaddr_ready !== 1'b1) $display("FAIL single_req_ready: got %b required 1", vaddr_ready);
    else passed++;
    tick();
    vaddr_valid = 1'b0;
    #1;
    total++;
    if (inst_ready !== 1'b1) $display("FAIL single_inst_ready: got %b required 1", inst_ready);
    else passed++;
    tick();
    tick();
    inst_i     = 32'h02800000;
    inst_valid = 1'b1;
    #1;
    total++;
    if ({is_fire, ib_valid} !== 2'b10)
      $display("FAIL single_fire_no_bypass: got %b required 10", {is_fire, ib_valid});
    else passed++;
    tick();
    inst_valid = 1'b0;
    #1;
    total++;
    if ({ib_valid, vaddr_o, inst_o} !== {1'b1, 32'h1c000000, 32'h02800000})
      $display("FAIL single_head: got %b %h %h required 1 1c000000 02800000", ib_valid, vaddr_o, inst_o);
    else passed++;
    tick();
    total++;
    if (ib_valid !== 1'b0) $display("FAIL single_drain: got %b required 0", ib_valid);
    else passed++;
  endtask

  task automatic test_pipelined();
    idle();
    ib_ready    = 1'b1;
    vaddr       = 32'h100;
    vaddr_valid = 1'b1;
    tick();
    vaddr = 32'h104;
    #1;
    total++;
    if (vaddr_ready !== 1'b1) $display("FAIL pipe_second_req: got %b required 1", vaddr_ready);
    else passed++;
    tick();
    vaddr      = 32'h108;
    inst_i     = 32'haaaa0001;
    inst_valid = 1'b1;
    #1;
    total++;
    if ({vaddr_ready, is_fire} !== 2'b01)
      $display("FAIL pipe_third_stalls: got %b required 01", {vaddr_ready, is_fire});
    else passed++;
    tick();
    inst_i = 32'hbbbb0002;
    #1;
    total++;
    if ({vaddr_ready, ib_valid, vaddr_o, inst_o} !== {2'b11, 32'h100, 32'haaaa0001})
      $display("FAIL pipe_head_a: got %b %b %h %h required 1 1 100 aaaa0001", vaddr_ready, ib_valid, vaddr_o, inst_o);
    else passed++;
    tick();
    vaddr_valid = 1'b0;
    inst_i      = 32'hcccc0003;
    #1;
    total++;
    if ({vaddr_o, inst_o} !== {32'h104, 32'hbbbb0002})
      $display("FAIL pipe_head_b: got %h %h required 104 bbbb0002", vaddr_o, inst_o);
    else passed++;
    tick();
    inst_valid = 1'b0;
    #1;
    total++;
    if ({vaddr_o, inst_o} !== {32'h108, 32'hcccc0003})
      $display("FAIL pipe_head_c: got %h %h required 108 cccc0003", vaddr_o, inst_o);
    else passed++;
    tick();
    total++;
    if (ib_valid !== 1'b0) $display("FAIL pipe_drain: got %b required 0", ib_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_va [4];
    logic [31:0] exp_in [4];
    exp_va[0] = 32'h304; exp_in[0] = 32'hb0000001;
    exp_va[1] = 32'h308; exp_in[1] = 32'hb0000002;
    exp_va[2] = 32'h30c; exp_in[2] = 32'hb0000003;
    exp_va[3] = 32'h310; exp_in[3] = 32'hb0000004;
    idle();
    ib_ready    = 1'b0;
    vaddr       = 32'h300;
    vaddr_valid = 1'b1;
    tick();
    vaddr = 32'h304;
    tick();
    vaddr      = 32'h308;
    inst_i     = 32'hb0000000;
    inst_valid = 1'b1;
    #1;
    total++;
    if (vaddr_ready !== 1'b0) $display("FAIL bp_pend_full: got %b required 0", vaddr_ready);
    else passed++;
    tick();
    inst_i = 32'hb0000001;
    tick();
    vaddr  = 32'h30c;
    inst_i = 32'hb0000002;
    tick();
    vaddr  = 32'h310;
    inst_i = 32'hb0000003;
    #1;
    total++;
    if (vaddr_ready !== 1'b0) $display("FAIL bp_credit_stall: got %b required 0", vaddr_ready);
    else passed++;
    tick();
    inst_valid = 1'b0;
    ib_ready   = 1'b1;
    #1;
    total++;
    if ({vaddr_ready, vaddr_o, inst_o} !== {1'b0, 32'h300, 32'hb0000000})
      $display("FAIL bp_pop_cycle: got %b %h %h required 0 300 b0000000", vaddr_ready, vaddr_o, inst_o);
    else passed++;
    tick();
    ib_ready = 1'b0;
    #1;
    total++;
    if ({vaddr_ready, vaddr_o} !== {1'b1, 32'h304})
      $display("FAIL bp_credit_return: got %b %h required 1 304", vaddr_ready, vaddr_o);
    else passed++;
    tick();
    vaddr_valid = 1'b0;
    inst_i      = 32'hb0000004;
    inst_valid  = 1'b1;
    ib_ready    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({ib_valid, vaddr_o, inst_o} !== {1'b1, exp_va[i], exp_in[i]})
        $display("FAIL bp_drain_%0d: got %b %h %h required 1 %h %h", i, ib_valid, vaddr_o, inst_o, exp_va[i], exp_in[i]);
      else passed++;
      tick();
      inst_valid = 1'b0;
    end
    total++;
    if (ib_valid !== 1'b0) $display("FAIL bp_empty: got %b required 0", ib_valid);
    else passed++;
  endtask

  task automatic test_flush();
    idle();
    ib_ready    = 1'b0;
    vaddr       = 32'h400;
    vaddr_valid = 1'b1;
    tick();
    vaddr = 32'h404;
    tick();
    vaddr_valid = 1'b0;
    inst_i      = 32'hc0000000;
    inst_valid  = 1'b1;
    tick();
    inst_valid  = 1'b0;
    vaddr       = 32'h408;
    vaddr_valid = 1'b1;
    tick();
    vaddr_valid = 1'b0;
    flush       = 1'b1;
    #1;
    total++;
    if ({vaddr_ready, ib_valid} !== 2'b01)
      $display("FAIL flush_cycle: got %b required 01", {vaddr_ready, ib_valid});
    else passed++;
    tick();
    flush = 1'b0;
    #1;
    total++;
    if ({ib_valid, vaddr_ready, inst_ready} !== 3'b001)
      $display("FAIL flush_after: got %b required 001", {ib_valid, vaddr_ready, inst_ready});
    else passed++;
    inst_i     = 32'hdead0000;
    inst_valid = 1'b1;
    #1;
    total++;
    if (is_fire !== 1'b0) $display("FAIL flush_drop1: got %b required 0", is_fire);
    else passed++;
    tick();
    inst_i = 32'hdead0001;
    #1;
    total++;
    if ({is_fire, vaddr_ready, inst_ready} !== 3'b011)
      $display("FAIL flush_drop2: got %b required 011", {is_fire, vaddr_ready, inst_ready});
    else passed++;
    tick();
    inst_valid = 1'b0;
    #1;
    total++;
    if ({inst_ready, ib_valid} !== 2'b00)
      $display("FAIL flush_disc_done: got %b required 00", {inst_ready, ib_valid});
    else passed++;
    ib_ready    = 1'b1;
    vaddr       = 32'h200;
    vaddr_valid = 1'b1;
    tick();
    vaddr_valid = 1'b0;
    inst_i      = 32'h0badcafe;
    inst_valid  = 1'b1;
    #1;
    total++;
    if (is_fire !== 1'b1) $display("FAIL flush_new_fire: got %b required 1", is_fire);
    else passed++;
    tick();
    inst_valid = 1'b0;
    #1;
    total++;
    if ({ib_valid, vaddr_o, inst_o} !== {1'b1, 32'h200, 32'h0badcafe})
      $display("FAIL flush_new_head: got %b %h %h required 1 200 0badcafe", ib_valid, vaddr_o, inst_o);
    else passed++;
    tick();
    total++;
    if (ib_valid !== 1'b0) $display("FAIL flush_only_one: got %b required 0", ib_valid);
    else passed++;
  endtask

  task automatic test_flush_coincident();
    idle();
    ib_ready    = 1'b1;
    vaddr       = 32'h500;
    vaddr_valid = 1'b1;
    tick();
    vaddr_valid = 1'b0;
    inst_i      = 32'heeee0000;
    inst_valid  = 1'b1;
    excp_flush  = 1'b1;
    #1;
    total++;
    if ({is_fire, inst_ready} !== 2'b01)
      $display("FAIL coinc_cycle: got %b required 01", {is_fire, inst_ready});
    else passed++;
    tick();
    idle();
    #1;
    total++;
    if ({inst_ready, ib_valid, vaddr_ready} !== 3'b001)
      $display("FAIL coinc_after: got %b required 001", {inst_ready, ib_valid, vaddr_ready});
    else passed++;
    ertn_flush = 1'b1;
    #1;
    total++;
    if (vaddr_ready !== 1'b0) $display("FAIL ertn_blocks_req: got %b required 0", vaddr_ready);
    else passed++;
    tick();
    idle();
  endtask

  task automatic test_excp_and_reset();
    idle();
    ib_ready    = 1'b0;
    vaddr       = 32'h600;
    vaddr_valid = 1'b1;
    tick();
    vaddr_valid = 1'b0;
    inst_i      = 32'h0;
    excp_i      = 1'b1;
    excp_num_i  = 4'h8;
    inst_valid  = 1'b1;
    tick();
    idle();
    #1;
    total++;
    if ({ib_valid, excp, excp_num, vaddr_o} !== {2'b11, 4'h8, 32'h600})
      $display("FAIL excp_head: got %b %b %h %h required 1 1 8 600", ib_valid, excp, excp_num, vaddr_o);
    else passed++;
    vaddr       = 32'h604;
    vaddr_valid = 1'b1;
    tick();
    vaddr_valid = 1'b0;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({ib_valid, inst_ready, excp, vaddr_ready} !== 4'b0001)
      $display("FAIL midreset_state: got %b required 0001", {ib_valid, inst_ready, excp, vaddr_ready});
    else passed++;
    total++;
    if (vaddr_o !== 32'h0) $display("FAIL midreset_vaddr_o: got %h required 0", vaddr_o);
    else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    proto_err = 0;
    test_reset();
    test_single();
    test_pipelined();
    test_backpressure();
    test_flush();
    test_flush_coincident();
    test_excp_and_reset();
    tick();
    total++;
    if (proto_err !== 0) $display("FAIL protocol: got %0d violations required 0", proto_err);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_resp_join_q.md
Name: if_resp_join_q

Overview:
Fetch-stage join/buffer between the icache request/response channels and the instruction buffer (IB). It tracks outstanding fetch addresses in order, pairs each returning instruction word (plus its fetch exception) with its address, and queues the pairs in a DEPTH-entry FIFO toward decode. It supports multiple in-flight fetches with credit-based backpressure. Responses to requests issued before a flush are discarded precisely.

Parameters:
ADDR_W, 32, fetch virtual-address width
INST_W, 32, instruction word width
EXCP_W, 4, exception-number width
PEND_DEPTH, 2, maximum outstanding icache requests (power of 2, >=1)
DEPTH, 4, output FIFO entries (power of 2, >= PEND_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline redirect (branch mispredict)
excp_flush  in  1  exception redirect
ertn_flush  in  1  ertn redirect
vaddr  in  ADDR_W  fetch address sent to icache
vaddr_valid  in  1  fetch request valid
vaddr_ready  out  1  request accepted this cycle when both valid and ready are high
inst_i  in  INST_W  icache response word
excp_i  in  1  response carries an exception
excp_num_i  in  EXCP_W  exception code
inst_valid  in  1  response valid
inst_ready  out  1  response accepted
inst_o  out  INST_W  head instruction
vaddr_o  out  ADDR_W  head address
excp  out  1  head exception flag
excp_num  out  EXCP_W  head exception code
ib_valid  out  1  head valid
ib_ready  in  1  IB consumes head
is_fire  out  1  a kept response was joined this cycle

Behaviour:
- Any flush (kill = flush | excp_flush | ertn_flush) takes effect at the clock edge. Reset has priority over kill.
- Reset state: ib_valid=0. All counts and pointers are 0. inst_o, vaddr_o, excp and excp_num are 0.
- Request side: vaddr_ready = !kill & (pend_cnt + disc_cnt < PEND_DEPTH) & (pend_cnt + out_cnt < DEPTH).
  - Credits use registered counts only. A pop in the same cycle does not free a credit until the next cycle.
  - A request fire pushes vaddr into the pending queue.
- Response side: inst_ready = (pend_cnt != 0) | (disc_cnt != 0).
  - Responses return in request order.
  - If disc_cnt != 0, an accepted response is dropped and disc_cnt decrements.
  - Otherwise the response pops the pending head and pushes {vaddr, inst_i, excp_i, excp_num_i} into the output FIFO. is_fire=1 in that cycle.
  - inst_valid while inst_ready=0 is a protocol error; the bench asserts on it.
- Output: a registered FIFO with no bypass. A pair joined at edge N is visible on ib_valid/inst_o after edge N.
  - A pop occurs when ib_valid & ib_ready.
  - Push and pop in the same cycle are allowed; out_cnt is then unchanged.
  - Pointers wrap modulo DEPTH.
- Kill:
  - Output FIFO cleared; ib_valid=0 next cycle.
  - Pending queue cleared.
  - disc_cnt_next = disc_cnt + pend_cnt - (inst_valid & inst_ready ? 1 : 0). A response arriving in the kill cycle is dropped and is not pushed.
  - is_fire is forced 0 during kill.
- Excp responses are joined like normal ones. The block does not stall on an exception; decode handles it.
- Invariants: pend_cnt + disc_cnt <= PEND_DEPTH; pend_cnt + out_cnt <= DEPTH. The output FIFO therefore never overflows, and inst_ready never depends on ib_ready.

Decomposition:
- Shared package (fetch pkg): EXCP_W default and the fetch-pair struct typedef {vaddr, inst, excp, excp_num}.
- One sub-module, fetch_sync_fifo (params WIDTH, DEPTH; push, pop, clear, count, head).
  - Instantiated twice: as the pending-address queue and as the output FIFO.
- The top level holds the credit logic, disc_cnt (width $clog2(PEND_DEPTH+1)) and kill handling.

Test Plan:
- Single fetch: vaddr=0x1c000000 accepted at cycle 0, inst 0x02800000 at cycle 3 → is_fire at cycle 3; ib_valid=1 with vaddr_o=0x1c000000 and inst_o=0x02800000 from cycle 4.
- Pipelined fetches with PEND_DEPTH=2: requests 0x100 and 0x104 back to back; responses A, B on consecutive cycles → IB sees (0x100,A) then (0x104,B) in order. A third request stalls until the first response returns.
- Backpressure: ib_ready=0 with DEPTH=4 → vaddr_ready falls once pend_cnt+out_cnt=4. After ib_ready=1 and one pop, vaddr_ready returns one cycle later. No entry is lost.
- Flush with 2 outstanding: flush at cycle 5 → ib_valid=0 at cycle 6 and disc_cnt=2. The next two responses are accepted and dropped (is_fire=0). A new request to 0x200 issued after the flush yields (0x200, word) only.
- Flush coincident with a response: pend_cnt=1, inst_valid=1 and excp_flush=1 in the same cycle → response dropped, disc_cnt stays 0, no IB entry.
- Exception pass-through and reset: response with excp_i=1 and excp_num_i=0x8 → excp=1 and excp_num=0x8 on that head. Reset asserted mid-traffic → all counts clear and ib_valid=0 next cycle.
